// File: rtl/mag_pkg.sv
// Shared constants for the sign-magnitude to BCD converter.
package mag_pkg;

  localparam int unsigned MAG_DATA_W = 8;
  localparam int unsigned MAG_DIGITS = 3;
  localparam logic [3:0]  BCD_BLANK  = 4'hF;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StNeg   = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  always_comb begin
    adj = digit;
    if (digit >= 4'd5) begin
      adj = digit + 4'd3;
    end
  end

endmodule

// File: rtl/mag_bcd_conv.sv
// Two's-complement {bin,light} to sign + BCD magnitude using sequential double-dabble.
// Optional MAG_BCD_BLANK_EN replaces leading zero digits (except ones) with the blank code.
module mag_bcd_conv
  import mag_pkg::*;
#(
  parameter int unsigned DATA_W = MAG_DATA_W,
  parameter int unsigned DIGITS = MAG_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  light,
  input  logic [DATA_W-2:0]     bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DATA_W + 1);

  logic [1:0]             state_q, state_d;
  logic [DATA_W-1:0]      mag_q, mag_d;
  logic [BcdW-1:0]        bcd_q, bcd_d;
  logic                   sign_q, sign_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic [BcdW-1:0]        bcd_adj;
  logic [BcdW+DATA_W-1:0] sr_shift;
  logic [BcdW-1:0]        bcd_shift;
  logic [BcdW-1:0]        bcd_fin;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_add3
    bcd_add3 u_add3 (
      .digit (bcd_q[4*g +: 4]),
      .adj   (bcd_adj[4*g +: 4])
    );
  end

  // The MSB shifted out is always zero given 10^DIGITS > 2^(DATA_W-1).
  assign sr_shift  = {bcd_adj, mag_q} << 1;
  assign bcd_shift = sr_shift[BcdW+DATA_W-1 -: BcdW];

  always_comb begin
    bcd_fin = bcd_shift;
`ifdef MAG_BCD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = int'(DIGITS) - 1; i > 0; i--) begin
        if (lead && (bcd_shift[4*i +: 4] == 4'h0)) begin
          bcd_fin[4*i +: 4] = BCD_BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mag_d   = {bin, light};
          state_d = StNeg;
        end
      end
      StNeg: begin
        sign_d  = mag_q[DATA_W-1];
        // 0x80 negates to 0x80, which read unsigned is the correct magnitude 128.
        mag_d   = mag_q[DATA_W-1] ? (~mag_q + DATA_W'(1)) : mag_q;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        bcd_d = bcd_shift;
        mag_d = sr_shift[DATA_W-1:0];
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_W - 1)) begin
          bcd_d   = bcd_fin;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mag_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sign      = sign_q;
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_mag_bcd_conv.sv
// Directed bench for mag_bcd_conv; expectations follow MAG_BCD_BLANK_EN when defined.
module tb_mag_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        light;
  logic [6:0]  bin;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [11:0] bcd;

  int n_checks;
  int n_fail;

  mag_bcd_conv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .light     (light),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] bl(input logic [11:0] x);
    logic [11:0] r;
    r = x;
`ifdef MAG_BCD_BLANK_EN
    if (r[11:8] == 4'h0) begin
      r[11:8] = 4'hF;
      if (r[7:4] == 4'h0) r[7:4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] v);
    {bin, light} = v;
  endtask

  task automatic accept(input logic [7:0] v);
    drive(v);
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      tick(1);
      n++;
    end
    check({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check({tag, "_pop"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  task automatic convert(input string tag, input logic [7:0] v,
                         input logic exp_sign, input logic [11:0] exp_bcd);
    accept(v);
    wait_valid(tag);
    check({tag, "_sign"}, 32'(sign), 32'(exp_sign));
    check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    pop(tag);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(8'h00);
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Zero, with exact latency: out_valid after the 9th edge following acceptance.
    accept(8'h00);
    check("zero_busy_in_ready", 32'(in_ready), 32'd0);
    tick(8);
    check("zero_latency_early", 32'(out_valid), 32'd0);
    tick(1);
    check("zero_latency_valid", 32'(out_valid), 32'd1);
    check("zero_sign", 32'(sign), 32'd0);
    check("zero_bcd", 32'(bcd), 32'(bl(12'h000)));
    pop("zero");

    convert("max_pos", 8'h7F, 1'b0, bl(12'h127));
    convert("min_neg", 8'h80, 1'b1, bl(12'h128));
    convert("neg_one", 8'hFF, 1'b1, bl(12'h001));

    // Backpressure: result held with out_ready low.
    accept(8'hF6);
    wait_valid("bp");
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {17'd0, out_valid, in_ready, sign, bcd},
            {17'd0, 1'b1, 1'b0, 1'b1, bl(12'h010)});
      tick(1);
    end
    pop("bp");

    // Asynchronous reset in the middle of SHIFT.
    accept(8'h55);
    tick(4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_clear", {17'd0, out_valid, in_ready, sign, bcd}, {17'd0, 1'b0, 1'b1, 1'b0, 12'h000});
    tick(1);
    rst_n = 1'b1;
    tick(12);
    check("mid_rst_no_valid", 32'(out_valid), 32'd0);
    convert("after_rst", 8'h55, 1'b0, bl(12'h085));

    // Input changes while busy are ignored.
    accept(8'h0C);
    drive(8'h99);
    in_valid = 1'b1;
    wait_valid("chg");
    in_valid = 1'b0;
    check("chg_sign", 32'(sign), 32'd0);
    check("chg_bcd", 32'(bcd), 32'(bl(12'h012)));
    pop("chg");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
